// File: rtl/program_loader.sv
// program_loader: loads a program from a UART byte stream into instruction memory.
//   The stream is a 4-byte little-endian word count N followed by 4N data bytes,
//   packed into little-endian 32-bit words.
// Latency: each word is written the cycle after its 4th byte arrives. The ack/nak
//   byte is presented the cycle after the last word (or after length/checksum check).
// Backpressure: rx has no backpressure and every byte is taken. tx_valid/tx_data
//   hold until tx_ready.
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to require a trailing byte
//   equal to the modulo-256 sum of all data bytes before the ack is sent.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   rx_data/rx_valid      - received byte strobe (may be back-to-back)
//   tx_data/tx_valid      - ack/nak byte to the transmitter, accepted on tx_ready
//   tx_ready
//   imem_we/imem_addr     - one-cycle instruction-memory word write
//   imem_wdata
//   core_start            - level, high after a successful load
//   busy                  - high from the first length byte until ack/nak accepted
//   error                 - sticky, high after a nak
module program_loader #(
  parameter int         ADDR_WIDTH = 12,
  parameter logic [7:0] ACK_BYTE   = 8'hAA,
  parameter logic [7:0] NAK_BYTE   = 8'hEE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_start,
  output logic                  busy,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_LEN,
    S_LCHK,
    S_DATA,
    S_CHK,
    S_ACK,
    S_NAK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [32:0]         CAPACITY = 33'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] WCNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_n;
  logic [1:0]            byte_cnt_q, byte_cnt_n;
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_n;
  logic [23:0]           asm_q, asm_n;
  logic [31:0]           len_q, len_n;
  logic [7:0]            tx_data_n;
  logic                  tx_valid_n;
  logic                  imem_we_n;
  logic [ADDR_WIDTH-1:0] imem_addr_n;
  logic [31:0]           imem_wdata_n;
  logic                  core_start_n;
  logic                  busy_n;
  logic                  error_n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_n;
`endif

  logic len_ok;
  logic last_word;

  // Word count is one bit wider than the address so N = 2**ADDR_WIDTH fits.
  assign len_ok    = (len_q != 32'd0) && ({1'b0, len_q} <= CAPACITY);
  assign last_word = (word_cnt_q + WCNT_ONE) == len_q[ADDR_WIDTH:0];

  // Lanes 0..2 are buffered; lane 3 completes the word straight from rx_data,
  // so the buffer is free for the next word's first byte in the write cycle.
  function automatic logic [23:0] put_lane(input logic [23:0] cur,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  b);
    logic [23:0] r;
    r = cur;
    case (lane)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r = cur;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LEN;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      asm_q      <= '0;
      len_q      <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_n;
      byte_cnt_q <= byte_cnt_n;
      word_cnt_q <= word_cnt_n;
      asm_q      <= asm_n;
      len_q      <= len_n;
      tx_data    <= tx_data_n;
      tx_valid   <= tx_valid_n;
      imem_we    <= imem_we_n;
      imem_addr  <= imem_addr_n;
      imem_wdata <= imem_wdata_n;
      core_start <= core_start_n;
      busy       <= busy_n;
      error      <= error_n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q      <= sum_n;
`endif
    end
  end

  always_comb begin
    state_n      = state_q;
    byte_cnt_n   = byte_cnt_q;
    word_cnt_n   = word_cnt_q;
    asm_n        = asm_q;
    len_n        = len_q;
    tx_data_n    = tx_data;
    tx_valid_n   = tx_valid;
    imem_we_n    = 1'b0;
    imem_addr_n  = imem_addr;
    imem_wdata_n = imem_wdata;
    core_start_n = core_start;
    busy_n       = busy;
    error_n      = error;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_n        = sum_q;
`endif

    case (state_q)
      S_LEN: begin
        if (rx_valid) begin
          busy_n     = 1'b1;
          byte_cnt_n = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            len_n   = {rx_data, asm_q};
            state_n = S_LCHK;
          end else begin
            asm_n = put_lane(asm_q, byte_cnt_q, rx_data);
          end
        end
      end

      // Length is checked here; a data byte sent back-to-back with the
      // length lands in this cycle and is kept if the length is accepted.
      S_LCHK: begin
        if (!len_ok) begin
          state_n    = S_NAK;
          tx_valid_n = 1'b1;
          tx_data_n  = NAK_BYTE;
        end else begin
          state_n    = S_DATA;
          word_cnt_n = '0;
          if (rx_valid) begin
            asm_n      = put_lane(asm_q, 2'd0, rx_data);
            byte_cnt_n = 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_n      = rx_data;
`endif
          end
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          byte_cnt_n = byte_cnt_q + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_n      = sum_q + rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            imem_we_n    = 1'b1;
            imem_wdata_n = {rx_data, asm_q};
            imem_addr_n  = word_cnt_q[ADDR_WIDTH-1:0];
            word_cnt_n   = word_cnt_q + WCNT_ONE;
            if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state_n    = S_CHK;
`else
              state_n    = S_ACK;
              tx_valid_n = 1'b1;
              tx_data_n  = ACK_BYTE;
`endif
            end
          end else begin
            asm_n = put_lane(asm_q, byte_cnt_q, rx_data);
          end
        end
      end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (rx_valid) begin
          tx_valid_n = 1'b1;
          if (rx_data == sum_q) begin
            state_n   = S_ACK;
            tx_data_n = ACK_BYTE;
          end else begin
            state_n   = S_NAK;
            tx_data_n = NAK_BYTE;
          end
        end
      end
`endif

      S_ACK: begin
        if (tx_valid && tx_ready) begin
          tx_valid_n   = 1'b0;
          busy_n       = 1'b0;
          core_start_n = 1'b1;
          state_n      = S_DONE;
        end
      end

      S_NAK: begin
        if (tx_valid && tx_ready) begin
          tx_valid_n = 1'b0;
          busy_n     = 1'b0;
          error_n    = 1'b1;
          state_n    = S_ERR;
        end
      end

      default: begin
        // DONE / ERR are terminal until rst.
      end
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader. Two instances share the input stimulus:
// dut_a uses the default 12-bit address, dut_b uses ADDR_WIDTH=4 so the
// capacity boundary (16 words) is reachable with a short stream.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready;

  always #5 clk = ~clk;

  logic [7:0]  a_tx_data;
  logic        a_tx_valid, a_imem_we, a_core_start, a_busy, a_error;
  logic [11:0] a_imem_addr;
  logic [31:0] a_imem_wdata;

  logic [7:0]  b_tx_data;
  logic        b_tx_valid, b_imem_we, b_core_start, b_busy, b_error;
  logic [3:0]  b_imem_addr;
  logic [31:0] b_imem_wdata;

  program_loader dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(tx_ready),
    .imem_we(a_imem_we), .imem_addr(a_imem_addr), .imem_wdata(a_imem_wdata),
    .core_start(a_core_start), .busy(a_busy), .error(a_error)
  );

  program_loader #(.ADDR_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(tx_ready),
    .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
    .core_start(b_core_start), .busy(b_busy), .error(b_error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Write / handshake logs, sampled on the falling edge and cleared by rst.
  logic [31:0] a_wa[$], a_wd[$], b_wa[$], b_wd[$];
  int          a_hs = 0, b_hs = 0;
  logic [7:0]  a_hs_dat = 8'h00, b_hs_dat = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      a_wa.delete(); a_wd.delete(); b_wa.delete(); b_wd.delete();
      a_hs = 0; b_hs = 0;
    end else begin
      if (a_imem_we) begin a_wa.push_back(32'(a_imem_addr)); a_wd.push_back(a_imem_wdata); end
      if (b_imem_we) begin b_wa.push_back(32'(b_imem_addr)); b_wd.push_back(b_imem_wdata); end
      if (a_tx_valid && tx_ready) begin a_hs++; a_hs_dat = a_tx_data; end
      if (b_tx_valid && tx_ready) begin b_hs++; b_hs_dat = b_tx_data; end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step(1);
    rx_valid = 1'b0;
  endtask

  // Sends a 32-bit value as four back-to-back bytes, least significant first.
  task automatic send4(input logic [31:0] w);
    send(w[7:0]); send(w[15:8]); send(w[23:16]); send(w[31:24]);
  endtask

  // Trailing checksum byte; without the checksum build it arrives in ACK
  // and must be ignored.
  task automatic finish_load(input logic [7:0] cs);
    send(cs);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    step(1);
    rst      = 1'b0;
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return a_tx_valid;
      1:       return a_core_start | a_error;
      default: return b_core_start | b_error;
    endcase
  endfunction

  task automatic wait_sel(input int sel, input string tag);
    int n = 0;
    while (!cond(sel) && n < 100) begin step(1); n++; end
    check(tag, 32'(cond(sel)), 32'd1);
  endtask

  task automatic check_reset(input string p);
    check({p, "_tx_data"},    32'(a_tx_data),    32'h0);
    check({p, "_tx_valid"},   32'(a_tx_valid),   32'h0);
    check({p, "_imem_we"},    32'(a_imem_we),    32'h0);
    check({p, "_imem_addr"},  32'(a_imem_addr),  32'h0);
    check({p, "_imem_wdata"}, a_imem_wdata,      32'h0);
    check({p, "_core_start"}, 32'(a_core_start), 32'h0);
    check({p, "_busy"},       32'(a_busy),       32'h0);
    check({p, "_error"},      32'(a_error),      32'h0);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    step(2);
    rst = 1'b0;

    // 1: two-word load, bytes back-to-back from the first length byte on.
    check_reset("t1_rst");
    send(8'h02);
    check("t1_busy_rise", 32'(a_busy), 32'h1);
    send(8'h00); send(8'h00); send(8'h00);
    send4(32'h00100513);
    send4(32'h00100073);
    finish_load(8'hAB);
    wait_sel(1, "t1_done_wait");
    check("t1_nwr",   32'(a_wd.size()), 32'd2);
    check("t1_addr0", a_wa[0], 32'h0);
    check("t1_data0", a_wd[0], 32'h00100513);
    check("t1_addr1", a_wa[1], 32'h1);
    check("t1_data1", a_wd[1], 32'h00100073);
    check("t1_hs",    32'(a_hs), 32'd1);
    check("t1_txdat", 32'(a_hs_dat), 32'hAA);
    check("t1_start", 32'(a_core_start), 32'h1);
    check("t1_busy",  32'(a_busy), 32'h0);
    check("t1_error", 32'(a_error), 32'h0);
    check("t1_txvld", 32'(a_tx_valid), 32'h0);

    // 2: zero length is rejected; later bytes are ignored.
    do_reset();
    send4(32'h0);
    wait_sel(0, "t2_nak_wait");
    check("t2_txdat", 32'(a_tx_data), 32'hEE);
    wait_sel(1, "t2_err_wait");
    check("t2_error", 32'(a_error), 32'h1);
    check("t2_start", 32'(a_core_start), 32'h0);
    check("t2_busy",  32'(a_busy), 32'h0);
    check("t2_hs",    32'(a_hs), 32'd1);
    send4(32'h00000001);
    send4(32'h00100513);
    step(2);
    check("t2_nwr",    32'(a_wd.size()), 32'd0);
    check("t2_txvld",  32'(a_tx_valid), 32'h0);
    check("t2_error2", 32'(a_error), 32'h1);
    check("t2_start2", 32'(a_core_start), 32'h0);

    // 3: ADDR_WIDTH=4 instance, exactly full (16 words), then one too many.
    do_reset();
    send4(32'h10);
    for (int k = 0; k < 16; k++)
      send4({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    finish_load(8'hE0);
    wait_sel(2, "t3_done_wait");
    check("t3_nwr", 32'(b_wd.size()), 32'd16);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t3_addr%0d", k), b_wa[k], 32'(k));
      check($sformatf("t3_data%0d", k), b_wd[k], {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    end
    check("t3_hs",    32'(b_hs), 32'd1);
    check("t3_txdat", 32'(b_hs_dat), 32'hAA);
    check("t3_start", 32'(b_core_start), 32'h1);

    do_reset();
    send4(32'h11);
    wait_sel(2, "t3_over_wait");
    check("t3_over_error", 32'(b_error), 32'h1);
    check("t3_over_start", 32'(b_core_start), 32'h0);
    check("t3_over_nwr",   32'(b_wd.size()), 32'd0);
    check("t3_over_txdat", 32'(b_hs_dat), 32'hEE);

    // 3b: top length byte set on the 12-bit instance is rejected.
    do_reset();
    send4(32'h01000000);
    wait_sel(1, "t3b_wait");
    check("t3b_error", 32'(a_error), 32'h1);
    check("t3b_nwr",   32'(a_wd.size()), 32'd0);

    // 4: ack held while the transmitter is stalled.
    do_reset();
    tx_ready = 1'b0;
    send4(32'h1);
    send4(32'hAABBCCDD);
    finish_load(8'h0E);
    wait_sel(0, "t4_ack_wait");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t4_hold_vld%0d", i),   32'(a_tx_valid),   32'h1);
      check($sformatf("t4_hold_dat%0d", i),   32'(a_tx_data),    32'hAA);
      check($sformatf("t4_hold_start%0d", i), 32'(a_core_start), 32'h0);
      step(1);
    end
    tx_ready = 1'b1;
    check("t4_start_early", 32'(a_core_start), 32'h0);
    step(1);
    check("t4_start",  32'(a_core_start), 32'h1);
    check("t4_txvld",  32'(a_tx_valid), 32'h0);
    check("t4_busy",   32'(a_busy), 32'h0);
    check("t4_hs",     32'(a_hs), 32'd1);
    check("t4_nwr",    32'(a_wd.size()), 32'd1);
    check("t4_addr0",  a_wa[0], 32'h0);
    check("t4_data0",  a_wd[0], 32'hAABBCCDD);

    // 5: reset after 6 of 8 data bytes, then a fresh one-word load.
    do_reset();
    send4(32'h2);
    send4(32'h00100513);
    send(8'h73); send(8'h00);
    check("t5_mid_nwr", 32'(a_wd.size()), 32'd1);
    do_reset();
    check_reset("t5_rst");
    send4(32'h1);
    send4(32'h12345678);
    finish_load(8'h14);
    wait_sel(1, "t5_done_wait");
    check("t5_nwr",   32'(a_wd.size()), 32'd1);
    check("t5_addr0", a_wa[0], 32'h0);
    check("t5_data0", a_wd[0], 32'h12345678);
    check("t5_start", 32'(a_core_start), 32'h1);
    check("t5_error", 32'(a_error), 32'h0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // 6: checksum match and mismatch.
    do_reset();
    send4(32'h1);
    send4(32'h04030201);
    send(8'h0A);
    wait_sel(1, "t6_ok_wait");
    check("t6_ok_start", 32'(a_core_start), 32'h1);
    check("t6_ok_error", 32'(a_error), 32'h0);
    check("t6_ok_data",  a_wd[0], 32'h04030201);
    check("t6_ok_txdat", 32'(a_hs_dat), 32'hAA);

    do_reset();
    send4(32'h1);
    send4(32'h04030201);
    send(8'h0B);
    wait_sel(1, "t6_bad_wait");
    check("t6_bad_nwr",   32'(a_wd.size()), 32'd1);
    check("t6_bad_data",  a_wd[0], 32'h04030201);
    check("t6_bad_txdat", 32'(a_hs_dat), 32'hEE);
    check("t6_bad_error", 32'(a_error), 32'h1);
    check("t6_bad_start", 32'(a_core_start), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
